present_dropper: RTL and testbench
==================================

Name: present_dropper

Overview:
- Source side of the present-drop interface.
- Decides when a present falls and which type it is.
- Drives the single-cycle drop pulse and present type consumed by the presents slot controller.
- Sits between the ball/rope collision logic (pop events) and the presents controller; paced by the game's one-second tick.

Parameters:
- LFSR_SEED, 16'hACE1, non-zero reset/recovery value of the random generator
- DROP_THRESH, 8'd64, drop when lfsr[7:0] < DROP_THRESH (64/256 = 25% per pop)
- PITY_POPS, 4'd6, consecutive non-dropping pops after which the next accepted pop always drops
- COOLDOWN_SEC, 4'd3, secClk ticks after a drop during which pops are ignored

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- ball_pop  in  1  one-cycle pulse, a ball was split or destroyed by the rope
- secClk  in  1  one-cycle pulse per second
- presentsVisible  in  1  level; presents enabled in the current game phase
- force_drop  in  1  one-cycle pulse, debug/level-start drop regardless of probability and cooldown
- dropPresent  out  1  registered one-cycle drop request
- nxt_present  out  2  registered present type, valid whenever dropPresent=1
- dropper_state  out  2  current FSM state, for debug/LEDs

Behaviour:
- Reset (async, resetN=0): state=IDLE, lfsr=LFSR_SEED, pity_cnt=0, cool_cnt=0, dropPresent=0, nxt_present=0.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts every clk in every state. If the register ever holds 0, load LFSR_SEED on the next clk.
- Type map from lfsr[11:8]:
  - 0-7 -> type 0
  - 8-11 -> type 1
  - 12-13 -> type 2
  - 14-15 -> type 3
- States are IDLE, ARMED and COOLDOWN. Encoding is 0/1/2; 3 is illegal and recovers to IDLE.
- IDLE:
  - dropPresent=0; pity_cnt and cool_cnt held at 0.
  - presentsVisible=1 -> ARMED on the next clk.
- ARMED, on ball_pop=1 (a "drop decision"):
  - Drop if lfsr[7:0] < DROP_THRESH, or if pity_cnt == PITY_POPS.
  - On drop: next cycle dropPresent=1, nxt_present=map(lfsr[11:8] sampled in the decision cycle), pity_cnt=0, cool_cnt=COOLDOWN_SEC, state=COOLDOWN.
  - No drop: pity_cnt+1, saturating at PITY_POPS.
- COOLDOWN:
  - ball_pop is ignored and pity_cnt is unchanged.
  - secClk decrements cool_cnt. When cool_cnt is 1 and secClk=1 -> ARMED.
  - COOLDOWN_SEC=0 -> return to ARMED on the cycle after the drop.
- force_drop (any state except IDLE): behaves as a drop decision that always drops. Beats a same-cycle ball_pop; only one pulse is produced. Sets cool_cnt=COOLDOWN_SEC and state=COOLDOWN.
- presentsVisible=0 (any state): next clk state=IDLE, pity_cnt=0, cool_cnt=0, dropPresent=0. This has priority over ball_pop and force_drop in the same cycle.
- Latency: decision cycle N -> dropPresent high in cycle N+1 for exactly one cycle. nxt_present holds its value after the pulse until the next drop.
- dropPresent is never high on two consecutive cycles; the consumer need not debounce.
- The dropper does not track consumer slot occupancy. A drop with all slots busy is silently discarded downstream; this is intended.
- Simultaneous ball_pop and secClk in ARMED: the pop is evaluated. In COOLDOWN only secClk acts.
- Reset asserted mid-COOLDOWN or during the pulse cycle: outputs clear immediately (async), with no residual pulse after release.

Decomposition:
- Shared package present_pkg:
  - present type enum (type 0-3, 2 bits), shared with the presents controller
  - dropper state enum
  - LFSR mask constant
- One sub-module: lfsr16, ports clk, resetN, seed, q[15:0]. It is free-running with zero recovery and is reused by ball-spawn logic.

Test Plan:
- Reset with presentsVisible=1: after release, dropper_state=ARMED on the 1st clk, dropPresent=0. lfsr equals the golden Galois sequence from 16'hACE1 for 100 cycles.
- DROP_THRESH=8'd255, one ball_pop at cycle N: dropPresent=1 only at N+1. nxt_present matches the model's map of lfsr[11:8] at N. State=COOLDOWN and cool_cnt=3.
- COOLDOWN_SEC=3, after a drop: 5 ball_pops and 2 secClk produce no drop. The 3rd secClk returns to ARMED. The next pop with DROP_THRESH=255 drops.
- DROP_THRESH=0, PITY_POPS=6: pops 1-6 produce no drop and pity_cnt reaches 6. Pop 7 produces dropPresent=1 and pity_cnt returns to 0.
- force_drop and ball_pop in the same cycle while in COOLDOWN: exactly one dropPresent pulse, cool_cnt reloaded to 3. Separately, presentsVisible=0 together with force_drop: no pulse, state=IDLE.
- 10k random pops with DROP_THRESH=64 and COOLDOWN_SEC=0: drop rate is 25%±3% (pity-adjusted model). Type histogram is near 50/25/12.5/12.5%. dropPresent is never high two cycles in a row.

Source files
------------

// File: rtl/present_pkg.sv
// Shared present-drop types: present kinds, dropper states and the Galois
// LFSR step reused by every pseudo-random source in the game.
package present_pkg;

  typedef enum logic [1:0] {
    PRESENT_T0 = 2'd0,
    PRESENT_T1 = 2'd1,
    PRESENT_T2 = 2'd2,
    PRESENT_T3 = 2'd3
  } present_type_e;

  typedef enum logic [1:0] {
    DROP_IDLE     = 2'd0,
    DROP_ARMED    = 2'd1,
    DROP_COOLDOWN = 2'd2,
    DROP_ILLEGAL  = 2'd3
  } dropper_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) nxt = nxt ^ LFSR_MASK;
    return nxt;
  endfunction

  // A uniform nibble splits 8/4/2/2 into the four present kinds.
  function automatic present_type_e map_present_type(input logic [3:0] sel);
    present_type_e t;
    if (!sel[3])      t = PRESENT_T0;
    else if (!sel[2]) t = PRESENT_T1;
    else if (!sel[1]) t = PRESENT_T2;
    else              t = PRESENT_T3;
    return t;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; an all-zero register reloads the seed so
// the generator can never lock up.
module lfsr16
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_q <= seed;
    end else if (r_q == 16'h0000) begin
      r_q <= seed;
    end else begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/present_dropper.sv
// Decides when a present falls and which kind it is, producing a registered
// single-cycle drop pulse for the presents slot controller.
module present_dropper
  import present_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [7:0]  DROP_THRESH  = 8'd64,
  parameter logic [3:0]  PITY_POPS    = 4'd6,
  parameter logic [3:0]  COOLDOWN_SEC = 4'd3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ball_pop,
  input  logic       secClk,
  input  logic       presentsVisible,
  input  logic       force_drop,
  output logic       dropPresent,
  output logic [1:0] nxt_present,
  output logic [1:0] dropper_state
);

  logic [15:0]    w_lfsr;
  logic           w_lfsr_unused;
  dropper_state_e r_state, w_state_nxt;
  logic [3:0]     r_pity_cnt, w_pity_nxt;
  logic [3:0]     r_cool_cnt, w_cool_nxt;
  logic           r_drop, w_drop_nxt;
  present_type_e  r_type, w_type_nxt;
  logic           w_force_ok;
  logic           w_accept;
  logic           w_fire;
  logic           w_take;

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .seed   (LFSR_SEED),
    .q      (w_lfsr)
  );

  assign w_lfsr_unused = &{1'b0, w_lfsr[15:12]};

  // A force landing on the pulse cycle is swallowed so pulses never abut.
  assign w_force_ok = force_drop && !r_drop;
  assign w_accept   = ((r_state == DROP_ARMED) && (ball_pop || w_force_ok)) ||
                      ((r_state == DROP_COOLDOWN) && w_force_ok);
  assign w_fire     = w_force_ok || (w_lfsr[7:0] < DROP_THRESH) ||
                      (r_pity_cnt == PITY_POPS);
  assign w_take     = w_accept && w_fire;

  always_comb begin
    w_state_nxt = r_state;
    w_pity_nxt  = r_pity_cnt;
    w_cool_nxt  = r_cool_cnt;
    w_drop_nxt  = 1'b0;
    w_type_nxt  = r_type;

    if (!presentsVisible) begin
      w_state_nxt = DROP_IDLE;
      w_pity_nxt  = 4'd0;
      w_cool_nxt  = 4'd0;
    end else if (w_take) begin
      w_drop_nxt  = 1'b1;
      w_type_nxt  = map_present_type(w_lfsr[11:8]);
      w_pity_nxt  = 4'd0;
      w_cool_nxt  = COOLDOWN_SEC;
      w_state_nxt = DROP_COOLDOWN;
    end else begin
      case (r_state)
        DROP_IDLE: begin
          w_state_nxt = DROP_ARMED;
          w_pity_nxt  = 4'd0;
          w_cool_nxt  = 4'd0;
        end
        DROP_ARMED: begin
          if (ball_pop && (r_pity_cnt < PITY_POPS)) begin
            w_pity_nxt = r_pity_cnt + 4'd1;
          end
        end
        DROP_COOLDOWN: begin
          // A zero count means the cooldown is only the pulse cycle itself.
          if (r_cool_cnt == 4'd0) begin
            w_state_nxt = DROP_ARMED;
          end else if (secClk) begin
            w_cool_nxt = r_cool_cnt - 4'd1;
            if (r_cool_cnt == 4'd1) w_state_nxt = DROP_ARMED;
          end
        end
        default: begin
          w_state_nxt = DROP_IDLE;
          w_pity_nxt  = 4'd0;
          w_cool_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= DROP_IDLE;
      r_pity_cnt <= 4'd0;
      r_cool_cnt <= 4'd0;
      r_drop     <= 1'b0;
      r_type     <= PRESENT_T0;
    end else begin
      r_state    <= w_state_nxt;
      r_pity_cnt <= w_pity_nxt;
      r_cool_cnt <= w_cool_nxt;
      r_drop     <= w_drop_nxt;
      r_type     <= w_type_nxt;
    end
  end

  assign dropPresent   = r_drop;
  assign nxt_present   = r_type;
  assign dropper_state = r_state;

endmodule

// File: tb/tb_present_dropper.sv
// Drives three dropper configurations with shared stimulus and checks them
// against a behavioural model of the drop rules every cycle.
module tb_present_dropper;

  localparam int N      = 3;
  localparam int HI     = 0;
  localparam int LO     = 1;
  localparam int RND    = 2;
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_COOL = 2;

  logic clk = 1'b0;
  logic resetN, ball_pop, secClk, presentsVisible, force_drop;
  logic [N-1:0] dropP;
  logic [1:0]   nxtP  [N];
  logic [1:0]   stP   [N];
  logic [3:0]   pityP [N];
  logic [3:0]   coolP [N];

  int thr[N]     = '{255, 0, 64};
  int pityMax[N] = '{6, 6, 6};
  int coolSec[N] = '{3, 3, 0};

  int mSt[N], mLfsr[N], mPity[N], mCool[N], mType[N];
  bit mDrop[N];
  bit prevDrop[N];
  int cur;
  bit pulse;

  int checks = 0;
  int failures = 0;
  bit cmpOn = 0;
  bit rndPhase = 0;
  int rndDecisions = 0;
  int rndDrops = 0;
  int hist[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  present_dropper #(.LFSR_SEED(16'hACE1), .DROP_THRESH(8'd255), .PITY_POPS(4'd6), .COOLDOWN_SEC(4'd3)) uHi (
    .clk(clk), .resetN(resetN), .ball_pop(ball_pop), .secClk(secClk),
    .presentsVisible(presentsVisible), .force_drop(force_drop),
    .dropPresent(dropP[HI]), .nxt_present(nxtP[HI]), .dropper_state(stP[HI]));

  present_dropper #(.LFSR_SEED(16'hACE1), .DROP_THRESH(8'd0), .PITY_POPS(4'd6), .COOLDOWN_SEC(4'd3)) uLo (
    .clk(clk), .resetN(resetN), .ball_pop(ball_pop), .secClk(secClk),
    .presentsVisible(presentsVisible), .force_drop(force_drop),
    .dropPresent(dropP[LO]), .nxt_present(nxtP[LO]), .dropper_state(stP[LO]));

  present_dropper #(.LFSR_SEED(16'hACE1), .DROP_THRESH(8'd64), .PITY_POPS(4'd6), .COOLDOWN_SEC(4'd0)) uRnd (
    .clk(clk), .resetN(resetN), .ball_pop(ball_pop), .secClk(secClk),
    .presentsVisible(presentsVisible), .force_drop(force_drop),
    .dropPresent(dropP[RND]), .nxt_present(nxtP[RND]), .dropper_state(stP[RND]));

  assign pityP[HI]  = uHi.r_pity_cnt;
  assign pityP[LO]  = uLo.r_pity_cnt;
  assign pityP[RND] = uRnd.r_pity_cnt;
  assign coolP[HI]  = uHi.r_cool_cnt;
  assign coolP[LO]  = uLo.r_cool_cnt;
  assign coolP[RND] = uRnd.r_cool_cnt;

  function automatic int galoisNext(input int v);
    if (v == 0) return 16'hACE1;
    return (v & 1) ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int typeOf(input int v);
    int nib;
    nib = (v >> 8) & 15;
    if (nib < 8) return 0;
    if (nib < 12) return 1;
    if (nib < 14) return 2;
    return 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit pop, input bit sec, input bit frc, input bit vis);
    ball_pop = pop;
    secClk = sec;
    force_drop = frc;
    presentsVisible = vis;
    @(negedge clk);
  endtask

  // Behavioural model of the drop rules, one slot per configuration.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < N; i++) begin
        mSt[i] = M_IDLE; mLfsr[i] = 16'hACE1; mPity[i] = 0;
        mCool[i] = 0; mDrop[i] = 0; mType[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        cur = mLfsr[i];
        pulse = mDrop[i];
        mLfsr[i] = galoisNext(cur);
        mDrop[i] = 0;
        if (!presentsVisible) begin
          mSt[i] = M_IDLE; mPity[i] = 0; mCool[i] = 0;
        end else if (mSt[i] == M_IDLE) begin
          mSt[i] = M_ARM;
        end else if ((mSt[i] == M_ARM && ball_pop) || (force_drop && !pulse)) begin
          if (rndPhase && i == RND && mSt[i] == M_ARM && ball_pop) rndDecisions++;
          if ((force_drop && !pulse) || (cur % 256) < thr[i] || mPity[i] == pityMax[i]) begin
            mDrop[i] = 1; mType[i] = typeOf(cur); mPity[i] = 0;
            mCool[i] = coolSec[i]; mSt[i] = M_COOL;
          end else if (mPity[i] < pityMax[i]) begin
            mPity[i]++;
          end
        end else if (mSt[i] == M_COOL) begin
          if (mCool[i] == 0) mSt[i] = M_ARM;
          else if (secClk) begin
            mCool[i]--;
            if (mCool[i] == 0) mSt[i] = M_ARM;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("lfsr_golden", uHi.w_lfsr, mLfsr[HI]);
      for (int i = 0; i < N; i++) begin
        checkOutput("dropPresent", dropP[i], mDrop[i]);
        checkOutput("nxt_present", nxtP[i], mType[i]);
        checkOutput("dropper_state", stP[i], mSt[i]);
        checkOutput("pity_cnt", pityP[i], mPity[i]);
        checkOutput("cool_cnt", coolP[i], mCool[i]);
        checkOutput("no_back_to_back", prevDrop[i] & dropP[i], 0);
        prevDrop[i] = dropP[i];
      end
      if (rndPhase && dropP[RND]) begin
        rndDrops++;
        hist[nxtP[RND]]++;
      end
    end
  end

  initial begin
    int gap;
    resetN = 0; ball_pop = 0; secClk = 0; force_drop = 0; presentsVisible = 1;
    repeat (2) @(negedge clk);
    cmpOn = 1;

    checkOutput("rst_state", stP[HI], 0);
    checkOutput("rst_drop", dropP[HI], 0);
    checkOutput("rst_type", nxtP[HI], 0);
    checkOutput("rst_lfsr", uHi.w_lfsr, 16'hACE1);
    checkOutput("model_rst_lfsr", mLfsr[HI], 16'hACE1);

    resetN = 1;
    applyStimulus(0, 0, 0, 1);
    checkOutput("armed_first_clk", stP[HI], 1);
    checkOutput("armed_no_drop", dropP[HI], 0);
    checkOutput("lfsr_step1", uHi.w_lfsr, 16'hE270);
    checkOutput("model_lfsr_step1", mLfsr[HI], 16'hE270);

    // Decision on lfsr E270: low byte 0x70 drops only for the 255 threshold.
    applyStimulus(1, 0, 0, 1);
    checkOutput("hi_drop_n1", dropP[HI], 1);
    checkOutput("hi_type_n1", nxtP[HI], 0);
    checkOutput("hi_state_cool", stP[HI], 2);
    checkOutput("hi_cool3", coolP[HI], 3);
    checkOutput("rnd_nodrop_n1", dropP[RND], 0);
    checkOutput("lfsr_step2", uHi.w_lfsr, 16'h7138);
    applyStimulus(0, 0, 0, 1);
    checkOutput("hi_drop_n2", dropP[HI], 0);

    applyStimulus(1, 0, 0, 1);
    checkOutput("cool_pop_a", dropP[HI], 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("cool_pop_b", dropP[HI], 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("cool_pop_c", dropP[HI], 0);
    checkOutput("rnd_drop_0E27", dropP[RND], 1);
    checkOutput("rnd_type_0E27", nxtP[RND], 3);
    applyStimulus(1, 1, 0, 1);
    checkOutput("cool_pop_d", dropP[HI], 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("cool_pop_e", dropP[HI], 0);
    checkOutput("cool_still", stP[HI], 2);
    checkOutput("cool_cnt1", coolP[HI], 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("cool_to_armed", stP[HI], 1);
    checkOutput("lfsr_6162", uHi.w_lfsr, 16'h6162);
    applyStimulus(1, 0, 0, 1);
    checkOutput("hi_drop_again", dropP[HI], 1);
    checkOutput("hi_type_again", nxtP[HI], 0);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lo_idle", stP[LO], 0);
    checkOutput("lo_pity_clr", pityP[LO], 0);
    applyStimulus(0, 0, 0, 1);
    for (int p = 1; p <= 6; p++) begin
      applyStimulus(1, 0, 0, 1);
      checkOutput("pity_nodrop", dropP[LO], 0);
      checkOutput("pity_count", pityP[LO], p);
    end
    applyStimulus(1, 0, 0, 1);
    checkOutput("pity_drop", dropP[LO], 1);
    checkOutput("pity_zero", pityP[LO], 0);

    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("lo_cool2", coolP[LO], 2);
    applyStimulus(1, 0, 1, 1);
    checkOutput("force_pulse", dropP[LO], 1);
    checkOutput("force_reload", coolP[LO], 3);
    checkOutput("force_state", stP[LO], 2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("force_single", dropP[LO], 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("force_again", dropP[LO], 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("force_on_pulse", dropP[LO], 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("invis_force_state", stP[LO], 0);
    checkOutput("invis_force_drop", dropP[LO], 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("idle_force_state", stP[LO], 1);
    checkOutput("idle_force_drop", dropP[LO], 0);

    applyStimulus(0, 0, 1, 1);
    checkOutput("pre_reset_pulse", dropP[LO], 1);
    #2 resetN = 0;
    #1;
    checkOutput("async_clr_drop", dropP[LO], 0);
    checkOutput("async_clr_state", stP[LO], 0);
    @(negedge clk);
    resetN = 1;
    applyStimulus(0, 0, 0, 1);
    checkOutput("post_reset_drop", dropP[LO], 0);
    checkOutput("post_reset_armed", stP[LO], 1);

    rndPhase = 1;
    for (int p = 0; p < 10000; p++) begin
      gap = $urandom_range(1, 8);
      repeat (gap) applyStimulus(0, ($urandom_range(0, 3) == 0), 0, 1);
      applyStimulus(1, ($urandom_range(0, 3) == 0), 0, 1);
    end
    repeat (3) applyStimulus(0, 0, 0, 1);
    rndPhase = 0;

    // Pity after six misses lifts the 25% base rate to about 28.9%.
    checkOutput("rnd_rate", ((rndDrops * 1000 / (rndDecisions + 1)) >= 259) &&
                            ((rndDrops * 1000 / (rndDecisions + 1)) <= 319), 1);
    checkOutput("hist_t0", ((hist[0] * 1000 / (rndDrops + 1)) >= 440) && ((hist[0] * 1000 / (rndDrops + 1)) <= 560), 1);
    checkOutput("hist_t1", ((hist[1] * 1000 / (rndDrops + 1)) >= 190) && ((hist[1] * 1000 / (rndDrops + 1)) <= 310), 1);
    checkOutput("hist_t2", ((hist[2] * 1000 / (rndDrops + 1)) >= 75) && ((hist[2] * 1000 / (rndDrops + 1)) <= 175), 1);
    checkOutput("hist_t3", ((hist[3] * 1000 / (rndDrops + 1)) >= 75) && ((hist[3] * 1000 / (rndDrops + 1)) <= 175), 1);

    cmpOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
